// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide unit.
package multdiv_pkg;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    typedef enum logic [2:0] {
        BoothZero,
        BoothPos1,
        BoothPos2,
        BoothNeg1,
        BoothNeg2
    } booth_op_e;

    function automatic int unsigned mul_iters(int unsigned width);
        return width / 2;
    endfunction

    function automatic int unsigned div_iters(int unsigned width);
        return width;
    endfunction

    function automatic int unsigned mul_lat(int unsigned width);
        return mul_iters(width) + 1;
    endfunction

    function automatic int unsigned div_lat(int unsigned width);
        return div_iters(width) + 1;
    endfunction

    function automatic int unsigned cnt_width(int unsigned width);
        return $clog2(width) + 1;
    endfunction

    // Radix-4 recode of {b[2i+1], b[2i], b[2i-1]}.
    function automatic booth_op_e booth_recode(logic [2:0] bits);
        booth_op_e op;
        case (bits)
            3'b001, 3'b010: op = BoothPos1;
            3'b011:         op = BoothPos2;
            3'b100:         op = BoothNeg2;
            3'b101, 3'b110: op = BoothNeg1;
            default:        op = BoothZero;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_r4_step.sv
// One radix-4 Booth iteration: recode two multiplier bits, add the selected
// multiple into the accumulator, then shift {acc, mq} right by two.
module booth_r4_step
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH+1:0] acc,
    input  logic [WIDTH-1:0] mq,
    input  logic             q_m1,
    output logic [WIDTH+1:0] acc_next,
    output logic [WIDTH-1:0] mq_next,
    output logic             q_m1_next
);

    logic [WIDTH+1:0] m_ext;
    logic [WIDTH+1:0] addend;
    logic [WIDTH+1:0] sum;
    booth_op_e        op;

    // Two guard bits keep +/-2M partial sums from overflowing.
    always_comb begin
        m_ext  = {{2{mcand[WIDTH-1]}}, mcand};
        op     = booth_recode({mq[1:0], q_m1});
        addend = '0;
        unique case (op)
            BoothZero: addend = '0;
            BoothPos1: addend = m_ext;
            BoothPos2: addend = m_ext << 1;
            BoothNeg1: addend = -m_ext;
            BoothNeg2: addend = -(m_ext << 1);
            default:   addend = '0;
        endcase
        sum       = acc + addend;
        acc_next  = {{2{sum[WIDTH+1]}}, sum[WIDTH+1:2]};
        mq_next   = {sum[1:0], mq[WIDTH-1:2]};
        q_m1_next = mq[1];
    end

endmodule

// File: rtl/multdiv_unit.sv
// Multi-cycle signed multiply (radix-4 Booth) / divide (non-restoring) unit
// with a destination tag carried from start to result.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             ctrl_flush,
    input  logic [TAG_W-1:0] in_tag,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned      CntW     = cnt_width(WIDTH);
    localparam logic [CntW-1:0]  MulIters = CntW'(mul_iters(WIDTH));
    localparam logic [CntW-1:0]  DivIters = CntW'(div_iters(WIDTH));
    localparam logic [WIDTH-1:0] MinVal   = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    // mcand holds the multiplicand (MUL) or divisor magnitude (DIV);
    // acc/mq are the Booth accumulator/multiplier or remainder/quotient.
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH+1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic             qm1_q, qm1_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             neg_q, neg_d;
    logic             div_zero_q, div_zero_d;
    logic             div_ovf_q, div_ovf_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    logic [WIDTH+1:0] booth_acc;
    logic [WIDTH-1:0] booth_mq;
    logic             booth_qm1;

    booth_r4_step #(
        .WIDTH(WIDTH)
    ) u_booth (
        .mcand    (mcand_q),
        .acc      (acc_q),
        .mq       (mq_q),
        .q_m1     (qm1_q),
        .acc_next (booth_acc),
        .mq_next  (booth_mq),
        .q_m1_next(booth_qm1)
    );

    logic [WIDTH+1:0] rem_shift;
    logic [WIDTH+1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH:0]   mul_hi;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    always_comb begin
        // Non-restoring step: the remainder sign picks add or subtract.
        rem_shift = {acc_q[WIDTH:0], mq_q[WIDTH-1]};
        rem_next  = acc_q[WIDTH+1] ? rem_shift + {2'b00, mcand_q}
                                   : rem_shift - {2'b00, mcand_q};
        quo_next  = {mq_q[WIDTH-2:0], ~rem_next[WIDTH+1]};
        mul_hi    = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
        abs_a     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        abs_b     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        acc_d      = acc_q;
        mq_d       = mq_q;
        qm1_d      = qm1_q;
        tag_d      = tag_q;
        neg_d      = neg_q;
        div_zero_d = div_zero_q;
        div_ovf_d  = div_ovf_q;
        result_d   = result_q;
        exc_d      = exc_q;
        out_tag_d  = out_tag_q;

        if (ctrl_flush) begin
            state_d = StIdle;
        end else if (ctrl_MULT || ctrl_DIV) begin
            cnt_d = '0;
            acc_d = '0;
            qm1_d = 1'b0;
            tag_d = in_tag;
            if (ctrl_MULT) begin
                state_d    = StMul;
                mcand_d    = data_operandA;
                mq_d       = data_operandB;
                neg_d      = 1'b0;
                div_zero_d = 1'b0;
                div_ovf_d  = 1'b0;
            end else begin
                state_d    = StDiv;
                mcand_d    = abs_b;
                mq_d       = abs_a;
                neg_d      = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                div_zero_d = (data_operandB == '0);
                div_ovf_d  = (data_operandA == MinVal) && (data_operandB == '1);
            end
        end else begin
            case (state_q)
                StMul: begin
                    if (cnt_q == MulIters) begin
                        state_d   = StDone;
                        result_d  = mq_q;
                        exc_d     = !((&mul_hi) || !(|mul_hi));
                        out_tag_d = tag_q;
                    end else begin
                        acc_d = booth_acc;
                        mq_d  = booth_mq;
                        qm1_d = booth_qm1;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StDiv: begin
                    if (cnt_q == DivIters) begin
                        state_d   = StDone;
                        exc_d     = div_zero_q || div_ovf_q;
                        out_tag_d = tag_q;
                        if (div_zero_q) begin
                            result_d = '0;
                        end else if (div_ovf_q) begin
                            result_d = MinVal;
                        end else begin
                            result_d = neg_q ? -mq_q : mq_q;
                        end
                    end else begin
                        acc_d = rem_next;
                        mq_d  = quo_next;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            mcand_q    <= '0;
            acc_q      <= '0;
            mq_q       <= '0;
            qm1_q      <= 1'b0;
            tag_q      <= '0;
            neg_q      <= 1'b0;
            div_zero_q <= 1'b0;
            div_ovf_q  <= 1'b0;
            result_q   <= '0;
            exc_q      <= 1'b0;
            out_tag_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mcand_q    <= mcand_d;
            acc_q      <= acc_d;
            mq_q       <= mq_d;
            qm1_q      <= qm1_d;
            tag_q      <= tag_d;
            neg_q      <= neg_d;
            div_zero_q <= div_zero_d;
            div_ovf_q  <= div_ovf_d;
            result_q   <= result_d;
            exc_q      <= exc_d;
            out_tag_q  <= out_tag_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign out_tag        = out_tag_q;
    assign data_resultRDY = (state_q == StDone);
    assign busy           = (state_q == StMul) || (state_q == StDiv);

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit at WIDTH=32 and WIDTH=8: directed
// vector table, hand-written restart/flush/reset sequences, random ops.
module tb_multdiv_unit;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic [31:0] a32 = '0, b32 = '0, res32;
    logic        m32 = 1'b0, d32 = 1'b0, f32 = 1'b0, exc32, rdy32, busy32;
    logic [4:0]  tin32 = '0, tout32;

    logic [7:0]  a8 = '0, b8 = '0, res8;
    logic        m8 = 1'b0, d8 = 1'b0, f8 = 1'b0, exc8, rdy8, busy8;
    logic [4:0]  tin8 = '0, tout8;

    multdiv_unit #(.WIDTH(32), .TAG_W(5)) dut32 (
        .clock         (clock),
        .reset         (reset),
        .data_operandA (a32),
        .data_operandB (b32),
        .ctrl_MULT     (m32),
        .ctrl_DIV      (d32),
        .ctrl_flush    (f32),
        .in_tag        (tin32),
        .data_result   (res32),
        .data_exception(exc32),
        .data_resultRDY(rdy32),
        .busy          (busy32),
        .out_tag       (tout32)
    );

    multdiv_unit #(.WIDTH(8), .TAG_W(5)) dut8 (
        .clock         (clock),
        .reset         (reset),
        .data_operandA (a8),
        .data_operandB (b8),
        .ctrl_MULT     (m8),
        .ctrl_DIV      (d8),
        .ctrl_flush    (f8),
        .in_tag        (tin8),
        .data_result   (res8),
        .data_exception(exc8),
        .data_resultRDY(rdy8),
        .busy          (busy8),
        .out_tag       (tout8)
    );

    typedef struct {
        bit          w8;
        bit          m;
        bit          d;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] res;
        bit          exc;
        int          lat;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain signed arithmetic on sign-extended operands.
    function automatic void model(input int w, input bit is_mul, input longint a,
                                  input longint b, output logic [31:0] res, output bit exc);
        longint      lo   = -(longint'(1) <<< (w - 1));
        longint      hi   = (longint'(1) <<< (w - 1)) - 1;
        logic [63:0] mask = (64'd1 << w) - 64'd1;
        longint      r;
        if (is_mul) begin
            r   = a * b;
            exc = (r < lo) || (r > hi);
        end else if (b == 0) begin
            r   = 0;
            exc = 1'b1;
        end else if (a == lo && b == -1) begin
            r   = lo;
            exc = 1'b1;
        end else begin
            r   = a / b;
            exc = 1'b0;
        end
        res = 32'(64'(r) & mask);
    endfunction

    // Drive a start pulse captured at the next rising edge (edge T); returns
    // at the falling edge just after T with operands scrambled.
    task automatic issue(input bit w8, input bit m, input bit d, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag);
        @(negedge clock);
        if (w8) begin
            a8 = a[7:0]; b8 = b[7:0]; m8 = m; d8 = d; tin8 = tag;
        end else begin
            a32 = a; b32 = b; m32 = m; d32 = d; tin32 = tag;
        end
        @(negedge clock);
        m32 = 1'b0; d32 = 1'b0; m8 = 1'b0; d8 = 1'b0;
        a32 = $urandom; b32 = $urandom; tin32 = 5'($urandom);
        a8 = 8'($urandom); b8 = 8'($urandom); tin8 = 5'($urandom);
    endtask

    task automatic wait_rdy(input bit w8, input int budget, output int lat,
                            output logic [31:0] res, output logic exc, output logic [4:0] otag,
                            output logic busy_early);
        lat = -1; res = '0; exc = 1'b0; otag = '0; busy_early = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clock);
            if (k == 1) busy_early = w8 ? busy8 : busy32;
            if (w8 ? rdy8 : rdy32) begin
                lat  = k;
                res  = w8 ? {24'd0, res8} : res32;
                exc  = w8 ? exc8 : exc32;
                otag = w8 ? tout8 : tout32;
                break;
            end
        end
    endtask

    task automatic count_rdy(input bit w8, input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clock);
            if (w8 ? rdy8 : rdy32) n++;
        end
    endtask

    task automatic check_vec(input vec_t v, input string name);
        int          lat;
        logic [31:0] res;
        logic        exc, busy_early;
        logic [4:0]  otag;
        issue(v.w8, v.m, v.d, v.a, v.b, v.tag);
        wait_rdy(v.w8, 60, lat, res, exc, otag, busy_early);
        check({name, " latency"}, 64'(lat), 64'(v.lat));
        check({name, " result"}, 64'(res), 64'(v.res));
        check({name, " exception"}, 64'(exc), 64'(v.exc));
        check({name, " out_tag"}, 64'(otag), 64'(v.tag));
        check({name, " busy at T+1"}, 64'(busy_early), 64'd1);
        @(negedge clock);
        check({name, " busy after"}, 64'(v.w8 ? busy8 : busy32), 64'd0);
        check({name, " rdy one cycle"}, 64'(v.w8 ? rdy8 : rdy32), 64'd0);
    endtask

    initial begin
        vec_t        vecs[$];
        int          lat, n;
        logic [31:0] res;
        logic        exc, busy_early;
        logic [4:0]  otag;

        #1 reset = 1'b1;
        #2;
        check("reset result32", 64'(res32), 64'd0);
        check("reset exc32", 64'(exc32), 64'd0);
        check("reset rdy32", 64'(rdy32), 64'd0);
        check("reset busy32", 64'(busy32), 64'd0);
        check("reset tag32", 64'(tout32), 64'd0);
        check("reset result8", 64'(res8), 64'd0);
        check("reset busy8", 64'(busy8), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        //                w8  m  d  a             b             tag  res           exc lat
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, 5'd9, 32'hFFFFFFEB, 1'b0, 17});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h10000, 32'h10000, 5'd10, 32'h0, 1'b1, 17});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11, 32'd1, 1'b0, 17});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, 5'd12, 32'hFFFFFFFD, 1'b0, 33});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 32'd5, 32'd0, 5'd13, 32'd0, 1'b1, 33});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000,
                         1'b1, 33});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 32'd12, 32'd4, 5'd15, 32'd48, 1'b0, 17});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 32'd100, 32'd7, 5'd16, 32'd14, 1'b0, 33});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 5'd17, 32'd14, 1'b0, 33});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000,
                         1'b1, 17});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h80, 32'hFF, 5'd19, 32'h80, 1'b1, 5});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h80, 32'h03, 5'd20, 32'hD6, 1'b0, 9});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h7F, 32'hFF, 5'd21, 32'h81, 1'b0, 9});

        foreach (vecs[i]) check_vec(vecs[i], $sformatf("vec%0d", i));

        // Restart: divide issued at T+5 of a multiply replaces it.
        issue(1'b0, 1'b1, 1'b0, 32'd6, 32'd7, 5'd1);
        repeat (3) @(negedge clock);
        issue(1'b0, 1'b0, 1'b1, 32'd100, 32'd7, 5'd2);
        wait_rdy(1'b0, 60, lat, res, exc, otag, busy_early);
        check("restart latency", 64'(lat), 64'd33);
        check("restart result", 64'(res), 64'd14);
        check("restart exception", 64'(exc), 64'd0);
        check("restart out_tag", 64'(otag), 64'd2);
        count_rdy(1'b0, 40, n);
        check("restart extra pulses", 64'(n), 64'd0);

        // Flush at T+3 of a multiply.
        issue(1'b0, 1'b1, 1'b0, 32'd5, 32'd5, 5'd3);
        repeat (2) @(negedge clock);
        f32 = 1'b1;
        @(negedge clock);
        f32 = 1'b0;
        count_rdy(1'b0, 40, n);
        check("flush pulses", 64'(n), 64'd0);
        check("flush held result", 64'(res32), 64'd14);
        check("flush held exception", 64'(exc32), 64'd0);
        check("flush held tag", 64'(tout32), 64'd2);
        check("flush busy", 64'(busy32), 64'd0);

        // Flush on the edge that would enter DONE.
        issue(1'b0, 1'b1, 1'b0, 32'd3, 32'd3, 5'd6);
        repeat (16) @(negedge clock);
        f32 = 1'b1;
        @(negedge clock);
        f32 = 1'b0;
        count_rdy(1'b0, 40, n);
        check("late flush pulses", 64'(n), 64'd0);
        check("late flush held result", 64'(res32), 64'd14);

        // Asynchronous reset mid-divide.
        issue(1'b0, 1'b0, 1'b1, 32'd1000, 32'd3, 5'd4);
        repeat (10) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("async reset result", 64'(res32), 64'd0);
        check("async reset exception", 64'(exc32), 64'd0);
        check("async reset rdy", 64'(rdy32), 64'd0);
        check("async reset busy", 64'(busy32), 64'd0);
        check("async reset tag", 64'(tout32), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        count_rdy(1'b0, 40, n);
        check("post reset pulses", 64'(n), 64'd0);
        check_vec('{1'b0, 1'b1, 1'b0, 32'd9, 32'd9, 5'd5, 32'd81, 1'b0, 17}, "post reset op");

        // Random operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            vec_t        v;
            logic [31:0] ra, rb;
            longint      sa, sb;
            int          mode, w;
            v.w8 = (i >= 25);
            w    = v.w8 ? 8 : 32;
            ra   = $urandom;
            rb   = $urandom;
            if (!v.w8 && $urandom_range(0, 1) == 1) ra = {{20{ra[11]}}, ra[11:0]};
            if (!v.w8 && $urandom_range(0, 1) == 1) rb = {{24{rb[7]}}, rb[7:0]};
            if ($urandom_range(0, 7) == 0) rb = '0;
            sa   = v.w8 ? longint'($signed(ra[7:0])) : longint'($signed(ra));
            sb   = v.w8 ? longint'($signed(rb[7:0])) : longint'($signed(rb));
            mode = int'($urandom_range(0, 2));
            v.m  = (mode != 1);
            v.d  = (mode != 0);
            v.a  = ra;
            v.b  = rb;
            v.tag = 5'($urandom);
            model(w, v.m, sa, sb, v.res, v.exc);
            v.lat = v.m ? (w / 2 + 1) : (w + 1);
            check_vec(v, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Parametrised, multi-cycle signed multiply/divide unit that sits beside the ALU in the execute stage of the 5-stage pipeline.
- The execute stage issues an operation with a one-cycle start pulse and receives a one-cycle ready pulse plus the result later.
- Each operation carries a destination-register tag, so hazard/stall logic can match the writeback.
- Multiply uses radix-4 Booth iteration; divide uses non-restoring iteration. Width is generic.

Parameters:
- WIDTH, 32, operand/result width in bits; must be even and >= 4.
- TAG_W, 5, width of the destination-register tag carried with each operation.

Ports:
- clock  in  1  master clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_operandA  in  WIDTH  signed dividend / multiplicand.
- data_operandB  in  WIDTH  signed divisor / multiplier.
- ctrl_MULT  in  1  start-multiply pulse.
- ctrl_DIV  in  1  start-divide pulse.
- ctrl_flush  in  1  cancels any in-flight operation (branch/exception flush).
- in_tag  in  TAG_W  destination register of the operation being started.
- data_result  out  WIDTH  signed result.
- data_exception  out  1  overflow or divide-by-zero flag for the result.
- data_resultRDY  out  1  one-cycle pulse: result, exception and out_tag are valid.
- busy  out  1  high while an operation is in flight.
- out_tag  out  TAG_W  tag latched at the start of the operation.

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE.
  - All outputs are 0: data_result, data_exception, data_resultRDY, busy, out_tag.
  - Counter, accumulators and all other internal registers are cleared.
- States:
  - IDLE: waiting for a start pulse.
  - MUL: WIDTH/2 Booth iterations.
  - DIV: WIDTH non-restoring iterations.
  - DONE: one cycle; drives data_resultRDY=1, then returns to IDLE.
- Start:
  - On the edge where ctrl_MULT or ctrl_DIV is 1 (edge T), latch both operands and in_tag, clear the counter, and enter MUL or DIV.
  - busy=1 from T through the edge that enters DONE.
- Priority:
  - ctrl_MULT and ctrl_DIV both 1: multiply wins.
  - ctrl_flush over start: if ctrl_flush is 1 on the same edge as a start, the start is ignored.
- Latency:
  - data_resultRDY is high in the cycle after edge T+LAT.
  - LAT_MUL = WIDTH/2 + 1 (17 at WIDTH=32).
  - LAT_DIV = WIDTH + 1 (33 at WIDTH=32).
  - The counter is $clog2(WIDTH)+1 bits; iteration ends when the counter reaches the iteration count.
- Output hold: data_result, data_exception and out_tag are registered at the DONE transition and held until the next DONE or reset. data_resultRDY is high for exactly one cycle.
- Restart: a start while busy aborts the current operation and begins the new one from edge T. The aborted operation never produces data_resultRDY.
- Flush: ctrl_flush=1 returns to IDLE on that edge and cancels a pending DONE. Held outputs keep their previous values.
- Multiply:
  - Full 2*WIDTH signed product; data_result = low WIDTH bits.
  - data_exception=1 iff the upper WIDTH+1 bits are not all equal (the product does not fit in signed WIDTH).
- Divide:
  - Signed, quotient truncated toward zero; magnitudes are divided and the sign is applied at the end. Remainder is discarded.
  - Divisor 0: data_result=0, data_exception=1. Full latency still applies, so timing is uniform.
  - MIN / -1: data_result=MIN, data_exception=1.
- Operand inputs may change freely after edge T; the unit uses only its latched copies.

Decomposition:
- Shared package multdiv_pkg holds:
  - the state enum (IDLE, MUL, DIV, DONE);
  - iteration-count and latency constants as functions of WIDTH;
  - the Booth recoding constants.
- One natural sub-module, booth_r4_step: combinational radix-4 recode plus add/shift, instantiated once inside MUL.
- Divide iteration stays inline.

Test Plan:
- WIDTH=32, ctrl_MULT with A=7, B=-3, tag=9 -> data_resultRDY in the cycle after edge T+17; result -21 (0xFFFFFFEB), exception 0, out_tag 9, busy low afterwards.
- ctrl_MULT with A=0x00010000, B=0x00010000 -> result 0x00000000, exception 1. Then A=-1, B=-1 -> result 1, exception 0.
- ctrl_DIV with A=-7, B=2 -> result -3 after edge T+33, exception 0. Then A=5, B=0 -> result 0, exception 1, same latency. Then A=0x80000000, B=-1 -> result 0x80000000, exception 1.
- Restart and flush:
  - ctrl_MULT (6*7), then ctrl_DIV (100/7) at T+5 -> exactly one ready pulse, result 14, at the cycle after (T+5)+33.
  - Separately, ctrl_flush at T+3 of a multiply -> no ready pulse, outputs unchanged.
- Simultaneous and reset cases:
  - ctrl_MULT and ctrl_DIV together (A=12, B=4) -> result 48 via multiply latency.
  - reset asserted asynchronously mid-divide -> all outputs 0 immediately, no ready pulse, next operation correct.
- WIDTH=8 instance:
  - -128 * -1 -> result 0x80, exception 1, at the cycle after edge T+5.
  - -128 / 3 -> result -42, at the cycle after edge T+9.
